wb_commit_multi: RTL and testbench
==================================

# wb_commit_multi

Parametrised multi-lane writeback/commit stage for the MIPS pipeline, the successor to the single-lane WB register. It takes one bundle of up to LANES results per cycle from MEM via a valid/ready handshake, registers it, and drives LANES register-file write ports plus matching forwarding outputs. It also detects BREAK at commit, halts the pipeline front-end, and counts retired instructions.

## Interface
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- LANES, 2, commit lanes per bundle; lane 0 is oldest in program order; range 1..4
- CNT_W, 32, retired-instruction counter width

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  MEM presents a bundle
- in_ready  out  1  stage accepts a bundle; equals (state==RUN)
- in_lane_valid  in  LANES  per-lane instruction present
- in_regWr  in  LANES  per-lane register write request
- in_regAddr  in  LANES*ADDR_W  per-lane destination; lane k at [k*ADDR_W +: ADDR_W]
- in_regData  in  LANES*DATA_W  per-lane write data
- in_inst  in  LANES*32  per-lane instruction word (debug, BREAK detection)
- in_pc  in  LANES*32  per-lane PC (debug)
- flush  in  1  discard the bundle being captured this cycle
- resume  in  1  leave HALT (debug restart)
- we  out  LANES  register-file write enables
- wAddr  out  LANES*ADDR_W  write addresses
- wData  out  LANES*DATA_W  write data
- wbu_regWr / wbu_regAddr / wbu_data  out  LANES / LANES*ADDR_W / LANES*DATA_W  forwarding copies of we / wAddr / wData
- is_break  out  1  one-cycle pulse when BREAK commits
- halted  out  1  state==HALT
- break_pc  out  32  PC of the last committed BREAK
- retired  out  CNT_W  committed-instruction count

## Operation
- States: RUN, HALT. Reset state is RUN.
- Capture: when in_valid && in_ready && !flush, the stage register loads the bundle with valid=1. Otherwise it loads a bubble (all lane valids 0).
- Commit lane k (from the register): cv[k] = valid && lane_valid[k] && !kill[k].
- Kill rule: a BREAK in lane j sets kill[k] for every k>j in the same bundle.
- BREAK decode: inst[31:26]==6'b000000 && inst[5:0]==6'b001101. The lowest valid lane decoding BREAK wins.
- Write enable: we[k] = cv[k] && regWr[k] && addr[k]!=0 && !(some m>k with cv[m], regWr[m], addr[m]==addr[k]). On same-address writes, the youngest lane wins.
- wAddr and wData come straight from the register. wbu_* equal we/wAddr/wData exactly.
- On BREAK commit:
  - is_break=1 for that cycle.
  - break_pc <= that lane's pc.
  - State goes to HALT next edge.
- HALT:
  - in_ready=0, so every capture is a bubble and we is all 0.
  - resume moves the state to RUN next edge.
- retired <= retired + popcount(cv). The BREAK instruction is counted; killed lanes are not. The counter wraps mod 2^CNT_W.

## Timing
- Latency: one cycle from bundle acceptance to we/wData valid.
- Outputs are combinational from the stage register only; no input-to-output combinational path except in_ready, which depends on state only.
- Reset values (synchronous; rst overrides everything):
  - we=0, wAddr=0, wData=0, wbu_*=0
  - is_break=0, halted=0, break_pc=0, retired=0
  - in_ready=1 in the cycle after reset
  - stage register valid=0
- Reset mid-HALT: returns to RUN. Reset with a bundle in the register: the bundle is discarded and not counted.
- flush and in_valid in the same cycle: flush wins and a bubble loads.
- resume while in RUN: ignored.
- resume in the same cycle as a BREAK commit: the BREAK wins and the state is HALT.
- The bundle containing BREAK is accepted in the cycle before its commit. The capture edge at which BREAK commits may still accept one more bundle, because in_ready is still 1. That bundle sits in the register during the first HALT cycle and must be suppressed: all commits are gated while state==HALT. It is lost; MEM must replay it after resume.

## Test plan
- Reset then idle: rst high 2 cycles, then in_valid=0 -> we=0, retired=0, in_ready=1, halted=0.
- LANES=2 bundle: lane0 r3<=0x11, lane1 r4<=0x22 -> next cycle we=2'b11, wAddr={4,3}, retired=2.
- Same address: both lanes write r5, lane0 0xAAAA, lane1 0xBBBB -> we=2'b10, r5 receives 0xBBBB. Write to r0 -> its we bit is 0, but it still counts as retired.
- BREAK in lane0 at pc 0x40, lane1 addi r6 -> is_break pulse, we=0, break_pc=0x40, retired+1. Afterwards halted=1, in_ready=0, and a bundle offered next cycle writes nothing.
- resume pulse in HALT -> in_ready=1 next cycle, new bundle commits normally. flush with in_valid=1 -> no write, retired unchanged.
- CNT_W=4, retired=15, commit 2 lanes -> retired=1. Assert rst during HALT -> RUN, all outputs at reset values.

Source files
------------

// File: rtl/wb_commit_multi.sv
// Multi-lane writeback/commit stage: registers one MEM bundle per cycle, drives
// LANES register-file write ports, halts on BREAK and counts retired instructions.
module wb_commit_multi #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int LANES  = 2,
   parameter int CNT_W  = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [LANES-1:0]         in_lane_valid,
   input  logic [LANES-1:0]         in_regWr,
   input  logic [LANES*ADDR_W-1:0]  in_regAddr,
   input  logic [LANES*DATA_W-1:0]  in_regData,
   input  logic [LANES*32-1:0]      in_inst,
   input  logic [LANES*32-1:0]      in_pc,
   input  logic                     flush,
   input  logic                     resume,
   output logic [LANES-1:0]         we,
   output logic [LANES*ADDR_W-1:0]  wAddr,
   output logic [LANES*DATA_W-1:0]  wData,
   output logic [LANES-1:0]         wbu_regWr,
   output logic [LANES*ADDR_W-1:0]  wbu_regAddr,
   output logic [LANES*DATA_W-1:0]  wbu_data,
   output logic                     is_break,
   output logic                     halted,
   output logic [31:0]              break_pc,
   output logic [CNT_W-1:0]         retired
);

   typedef enum logic [0:0] {RUN = 1'b0, HALT = 1'b1} state_t;

   state_t                    state_reg;
   logic                      valid_reg;
   logic [LANES-1:0]          lane_valid_reg;
   logic [LANES-1:0]          reg_wr_reg;
   logic [LANES*ADDR_W-1:0]   addr_reg;
   logic [LANES*DATA_W-1:0]   data_reg;
   logic [LANES*32-1:0]       inst_reg;
   logic [LANES*32-1:0]       pc_reg;
   logic [31:0]               break_pc_reg;
   logic [CNT_W-1:0]          retired_reg;

   logic [LANES-1:0]          brk;
   logic [LANES-1:0]          kill;
   logic [LANES-1:0]          cv;
   logic [LANES-1:0]          we_next;
   logic                      break_commit;
   logic [31:0]               brk_pc;
   logic [CNT_W-1:0]          commit_cnt;
   logic                      capture;

   assign in_ready = (state_reg == RUN);
   assign capture  = in_valid && in_ready && !flush;

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         logic shadowed;

         assign brk[gi] = lane_valid_reg[gi]
                        && (inst_reg[gi*32+26 +: 6] == 6'b000000)
                        && (inst_reg[gi*32 +: 6] == 6'b001101);

         // Anything younger than a BREAK in the same bundle never commits.
         if (gi == 0) begin : g_k0
            assign kill[gi] = 1'b0;
         end else begin : g_kn
            assign kill[gi] = |brk[gi-1:0];
         end

         // Commits are gated in HALT so the bundle accepted alongside a BREAK commit is dropped.
         assign cv[gi] = valid_reg && lane_valid_reg[gi] && !kill[gi] && (state_reg == RUN);

         always_comb begin
            shadowed = 1'b0;
            for (int m = gi + 1; m < LANES; m++) begin
               if (cv[m] && reg_wr_reg[m]
                   && (addr_reg[m*ADDR_W +: ADDR_W] == addr_reg[gi*ADDR_W +: ADDR_W]))
                  shadowed = 1'b1;
            end
         end

         assign we_next[gi] = cv[gi] && reg_wr_reg[gi]
                            && (addr_reg[gi*ADDR_W +: ADDR_W] != '0) && !shadowed;
      end
   endgenerate

   assign break_commit = |(cv & brk);

   // Scan from youngest to oldest so the lowest BREAK lane's PC wins.
   always_comb begin
      brk_pc = 32'h0;
      for (int k = LANES - 1; k >= 0; k--) begin
         if (brk[k])
            brk_pc = pc_reg[k*32 +: 32];
      end
   end

   always_comb begin
      commit_cnt = '0;
      for (int k = 0; k < LANES; k++)
         commit_cnt = commit_cnt + CNT_W'(cv[k]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= RUN;
         valid_reg      <= 1'b0;
         lane_valid_reg <= '0;
         reg_wr_reg     <= '0;
         addr_reg       <= '0;
         data_reg       <= '0;
         inst_reg       <= '0;
         pc_reg         <= '0;
         break_pc_reg   <= 32'h0;
         retired_reg    <= '0;
      end else begin
         retired_reg <= retired_reg + commit_cnt;

         if (break_commit) begin
            break_pc_reg <= brk_pc;
            state_reg    <= HALT;
         end else if (state_reg == HALT && resume) begin
            state_reg <= RUN;
         end

         if (capture) begin
            valid_reg      <= 1'b1;
            lane_valid_reg <= in_lane_valid;
            reg_wr_reg     <= in_regWr;
            addr_reg       <= in_regAddr;
            data_reg       <= in_regData;
            inst_reg       <= in_inst;
            pc_reg         <= in_pc;
         end else begin
            valid_reg      <= 1'b0;
            lane_valid_reg <= '0;
         end
      end
   end

   assign we          = we_next;
   assign wAddr       = addr_reg;
   assign wData       = data_reg;
   assign wbu_regWr   = we_next;
   assign wbu_regAddr = addr_reg;
   assign wbu_data    = data_reg;
   assign is_break    = break_commit;
   assign halted      = (state_reg == HALT);
   assign break_pc    = break_pc_reg;
   assign retired     = retired_reg;

endmodule

// File: tb/tb_wb_commit_multi.sv
// Directed bench for wb_commit_multi (LANES=2, CNT_W=4): vector table plus
// hand-written BREAK / HALT / resume / wrap / reset sequences.
module tb_wb_commit_multi;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int L  = 2;
   localparam int CW = 4;
   localparam logic [31:0] BRK  = 32'h0000_000D;
   localparam logic [31:0] ADDI = 32'h2000_0001;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [L-1:0]    in_lane_valid;
   logic [L-1:0]    in_regWr;
   logic [L*AW-1:0] in_regAddr;
   logic [L*DW-1:0] in_regData;
   logic [L*32-1:0] in_inst;
   logic [L*32-1:0] in_pc;
   logic            flush;
   logic            resume;
   logic [L-1:0]    we;
   logic [L*AW-1:0] wAddr;
   logic [L*DW-1:0] wData;
   logic [L-1:0]    wbu_regWr;
   logic [L*AW-1:0] wbu_regAddr;
   logic [L*DW-1:0] wbu_data;
   logic            is_break;
   logic            halted;
   logic [31:0]     break_pc;
   logic [CW-1:0]   retired;

   int pass_cnt  = 0;
   int total_cnt = 0;

   wb_commit_multi #(.DATA_W(DW), .ADDR_W(AW), .LANES(L), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_lane_valid(in_lane_valid), .in_regWr(in_regWr), .in_regAddr(in_regAddr),
      .in_regData(in_regData), .in_inst(in_inst), .in_pc(in_pc),
      .flush(flush), .resume(resume),
      .we(we), .wAddr(wAddr), .wData(wData),
      .wbu_regWr(wbu_regWr), .wbu_regAddr(wbu_regAddr), .wbu_data(wbu_data),
      .is_break(is_break), .halted(halted), .break_pc(break_pc), .retired(retired)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  lv;
      logic [1:0]  wr;
      logic [4:0]  a0;
      logic [31:0] d0;
      logic [4:0]  a1;
      logic [31:0] d1;
      logic        fl;
      logic [1:0]  ewe;
      int          pop;
   } vec_t;

   vec_t tbl [8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] lv, input logic [1:0] wr,
                        input logic [4:0] a0, input logic [31:0] d0,
                        input logic [4:0] a1, input logic [31:0] d1,
                        input logic [31:0] i0, input logic [31:0] i1,
                        input logic [31:0] p0, input logic [31:0] p1);
      in_valid      = 1'b1;
      in_lane_valid = lv;
      in_regWr      = wr;
      in_regAddr    = {a1, a0};
      in_regData    = {d1, d0};
      in_inst       = {i1, i0};
      in_pc         = {p1, p0};
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_we"}, 64'(we), 64'h0);
      chk({tag, "_wbu_we"}, 64'(wbu_regWr), 64'h0);
      chk({tag, "_waddr"}, 64'(wAddr), 64'h0);
      chk({tag, "_wdata"}, 64'(wData), 64'h0);
      chk({tag, "_retired"}, 64'(retired), 64'h0);
      chk({tag, "_in_ready"}, 64'(in_ready), 64'h1);
      chk({tag, "_halted"}, 64'(halted), 64'h0);
      chk({tag, "_is_break"}, 64'(is_break), 64'h0);
      chk({tag, "_break_pc"}, 64'(break_pc), 64'h0);
   endtask

   initial begin
      logic [CW-1:0] exp_ret;

      //        lv     wr     a0  d0            a1  d1            fl    ewe    pop
      tbl[0] = '{2'b11, 2'b11, 5'd3,  32'h11,   5'd4,  32'h22,   1'b0, 2'b11, 2};
      tbl[1] = '{2'b11, 2'b11, 5'd5,  32'hAAAA, 5'd5,  32'hBBBB, 1'b0, 2'b10, 2};
      tbl[2] = '{2'b11, 2'b11, 5'd0,  32'h55,   5'd7,  32'h77,   1'b0, 2'b10, 2};
      tbl[3] = '{2'b01, 2'b11, 5'd8,  32'h88,   5'd9,  32'h99,   1'b0, 2'b01, 1};
      tbl[4] = '{2'b10, 2'b11, 5'd9,  32'h90,   5'd9,  32'h91,   1'b0, 2'b10, 1};
      tbl[5] = '{2'b11, 2'b00, 5'd1,  32'h1,    5'd2,  32'h2,    1'b0, 2'b00, 2};
      tbl[6] = '{2'b11, 2'b11, 5'd6,  32'h66,   5'd7,  32'h67,   1'b1, 2'b00, 0};
      tbl[7] = '{2'b11, 2'b01, 5'd10, 32'hA0,   5'd10, 32'hA1,   1'b0, 2'b01, 2};

      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; resume = 1'b0;
      in_lane_valid = '0; in_regWr = '0; in_regAddr = '0; in_regData = '0;
      in_inst = '0; in_pc = '0;
      tick(); tick();
      rst = 1'b0;
      chk_reset_vals("reset");

      resume = 1'b1;
      tick();
      resume = 1'b0;
      chk("resume_in_run_halted", 64'(halted), 64'h0);
      chk("resume_in_run_ready", 64'(in_ready), 64'h1);

      exp_ret = '0;
      for (int i = 0; i < 8; i++) begin
         drive(tbl[i].lv, tbl[i].wr, tbl[i].a0, tbl[i].d0, tbl[i].a1, tbl[i].d1,
               ADDI, ADDI, 32'h100 + 32'(i*8), 32'h104 + 32'(i*8));
         flush = tbl[i].fl;
         tick();
         flush = 1'b0;
         chk($sformatf("v%0d_we", i), 64'(we), 64'(tbl[i].ewe));
         chk($sformatf("v%0d_wbu_we", i), 64'(wbu_regWr), 64'(tbl[i].ewe));
         chk($sformatf("v%0d_is_break", i), 64'(is_break), 64'h0);
         chk($sformatf("v%0d_retired", i), 64'(retired), 64'(exp_ret));
         if (tbl[i].ewe[0]) begin
            chk($sformatf("v%0d_waddr0", i), 64'(wAddr[4:0]), 64'(tbl[i].a0));
            chk($sformatf("v%0d_wdata0", i), 64'(wData[31:0]), 64'(tbl[i].d0));
         end
         if (tbl[i].ewe[1]) begin
            chk($sformatf("v%0d_waddr1", i), 64'(wAddr[9:5]), 64'(tbl[i].a1));
            chk($sformatf("v%0d_wdata1", i), 64'(wData[63:32]), 64'(tbl[i].d1));
            chk($sformatf("v%0d_wbu_data1", i), 64'(wbu_data[63:32]), 64'(tbl[i].d1));
         end
         exp_ret = exp_ret + CW'(tbl[i].pop);
      end

      // BREAK in lane 0 kills the younger addi in lane 1
      drive(2'b11, 2'b01, 5'd0, 32'h0, 5'd6, 32'h6, BRK, ADDI, 32'h40, 32'h44);
      tick();
      chk("brk0_is_break", 64'(is_break), 64'h1);
      chk("brk0_we", 64'(we), 64'h0);
      chk("brk0_retired", 64'(retired), 64'(exp_ret));
      chk("brk0_in_ready", 64'(in_ready), 64'h1);
      exp_ret = exp_ret + 4'd1;

      // This bundle is accepted on the BREAK commit edge and must be dropped
      drive(2'b01, 2'b01, 5'd11, 32'hB1, 5'd0, 32'h0, ADDI, ADDI, 32'h48, 32'h4C);
      tick();
      chk("halt_halted", 64'(halted), 64'h1);
      chk("halt_in_ready", 64'(in_ready), 64'h0);
      chk("halt_we", 64'(we), 64'h0);
      chk("halt_is_break", 64'(is_break), 64'h0);
      chk("halt_break_pc", 64'(break_pc), 64'h40);
      chk("halt_retired", 64'(retired), 64'(exp_ret));
      tick();
      chk("halt2_we", 64'(we), 64'h0);
      chk("halt2_retired", 64'(retired), 64'(exp_ret));
      chk("halt2_halted", 64'(halted), 64'h1);

      in_valid = 1'b0; resume = 1'b1;
      tick();
      resume = 1'b0;
      chk("resume_halted", 64'(halted), 64'h0);
      chk("resume_in_ready", 64'(in_ready), 64'h1);
      chk("resume_retired", 64'(retired), 64'(exp_ret));

      drive(2'b01, 2'b01, 5'd12, 32'h1234, 5'd0, 32'h0, ADDI, ADDI, 32'h48, 32'h4C);
      tick();
      chk("post_resume_we", 64'(we), 64'h1);
      chk("post_resume_wdata0", 64'(wData[31:0]), 64'h1234);
      chk("post_resume_retired", 64'(retired), 64'(exp_ret));
      exp_ret = exp_ret + 4'd1;

      drive(2'b01, 2'b01, 5'd14, 32'hE, 5'd0, 32'h0, ADDI, ADDI, 32'h50, 32'h54);
      tick();
      chk("one_lane_retired", 64'(retired), 64'(exp_ret));
      exp_ret = exp_ret + 4'd1;

      drive(2'b11, 2'b11, 5'd1, 32'h1, 5'd2, 32'h2, ADDI, ADDI, 32'h58, 32'h5C);
      tick();
      chk("pre_wrap_retired", 64'(retired), 64'hF);
      chk("pre_wrap_we", 64'(we), 64'h3);

      // BREAK in lane 1 with resume asserted in the commit cycle: BREAK wins
      drive(2'b11, 2'b11, 5'd13, 32'hD, 5'd0, 32'h0, ADDI, BRK, 32'h7C, 32'h80);
      tick();
      chk("wrap_retired", 64'(retired), 64'h1);
      chk("brk1_we", 64'(we), 64'h1);
      chk("brk1_waddr0", 64'(wAddr[4:0]), 64'd13);
      chk("brk1_is_break", 64'(is_break), 64'h1);
      in_valid = 1'b0; resume = 1'b1;
      tick();
      resume = 1'b0;
      chk("brk1_halted", 64'(halted), 64'h1);
      chk("brk1_break_pc", 64'(break_pc), 64'h80);
      chk("brk1_retired", 64'(retired), 64'h3);

      // Reset while halted, with a bundle offered at the same time
      drive(2'b11, 2'b11, 5'd3, 32'h3, 5'd4, 32'h4, ADDI, ADDI, 32'h90, 32'h94);
      rst = 1'b1;
      tick();
      rst = 1'b0; in_valid = 1'b0;
      chk_reset_vals("halt_reset");
      tick();
      chk("after_reset_retired", 64'(retired), 64'h0);
      chk("after_reset_we", 64'(we), 64'h0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
